demosaic_scan_controller: RTL and testbench
===========================================

# demosaic_scan_controller

Sequencer for the 3x3 demosaic datapath. On a start pulse it raster-scans a WIDTH x HEIGHT Bayer image and drives the datapath controls for each pixel: memory read address, edge classification (lateral/vertical) and Bayer colour phase. It captures the filter's combinational RGB result into an output register and presents it as a valid/ready RGBA stream with full backpressure, then pulses done. It replaces the free-running pixel counter; the memory and filter stay purely combinational.

## Interface
Parameters:
- WIDTH, 40, pixels per row
- HEIGHT, 30, rows per frame
- X_BITS, 6, width of x address (must hold WIDTH-1)
- Y_BITS, 5, width of y address (must hold HEIGHT-1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the frame; sampled in every state
- bayer_phase  in  2  bit0 = x parity offset, bit1 = y parity offset; latched when start is accepted
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last pixel is accepted
- address_x  out  X_BITS  current scan column, to memory
- address_y  out  Y_BITS  current scan row, to memory
- lateral  out  2  0 Left (x==0), 2 Right (x==WIDTH-1), else 1 Center
- vertical  out  2  0 Top (y==0), 2 Bottom (y==HEIGHT-1), else 1 Middle
- color  out  2  0 Red, 1 Blue, 2 GreenBesideRed, 3 GreenBesideBlue
- filt_red, filt_green, filt_blue  in  8 each  filter result for the current address, same cycle
- out_valid  out  1  output register holds a pixel
- out_ready  in  1  consumer accepts when out_valid && out_ready at an edge
- out_x  out  X_BITS  column of held pixel
- out_y  out  Y_BITS  row of held pixel
- out_rgba  out  32  {8'hFF, blue, green, red} of held pixel

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: counters x=y=0. start && !abort -> latch bayer_phase, go RUN.
- RUN: issue = !out_valid || out_ready. On issue at the edge: load the output register with {filt_*, x, y}, set out_valid, advance the counter (x+1; at x==WIDTH-1, x=0 and y+1). Issuing pixel (WIDTH-1, HEIGHT-1) -> DRAIN, with counters returning to 0.
- DRAIN: no issue. out_valid && out_ready -> clear out_valid, go DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort in any state: next state IDLE, out_valid cleared, counters cleared, done not pulsed. abort wins over start and over any issue in the same cycle.
- start while busy or in DONE: ignored.
- Output register holds value and coordinates stable while out_valid && !out_ready.
- Controls are combinational from counters and latched phase: px = x[0]^phase[0], py = y[0]^phase[1]; {px,py}: 00 Red, 11 Blue, 10 GreenBesideRed, 01 GreenBesideBlue.
- Counter compares are exact against WIDTH-1 and HEIGHT-1; no out-of-range address is ever driven.

## Timing
- Reset (async assert, sync release is the integrator's concern): state IDLE, x=y=0, phase=0, out_valid=0, out_x=out_y=0, out_rgba=0, busy=0, done=0. Combinational outputs at reset: address 0/0, lateral Left, vertical Top, color Red.
- Latency: memory plus filter is 0 cycles. The pixel issued in a cycle appears on out_* after the next edge.
- Throughput: 1 pixel/clock while out_ready=1.
- With start accepted at edge E and out_ready held high: pixel i (raster index) is issued in the cycle after edge E+i. out_valid is high from E+1 through E+WIDTH*HEIGHT. busy is high from E to E+WIDTH*HEIGHT+1. done is high from E+WIDTH*HEIGHT+1 to +2, then IDLE.
- Each cycle with out_ready=0 while out_valid=1 delays all later events by one cycle. No pixel is dropped or duplicated.
- A new start is accepted no earlier than the cycle after done.

## Test plan
- Full frame, phase 0, out_ready=1: 1200 beats, raster order, out_x/out_y match index. done asserts exactly once, 1201 edges after start. Stubbed filt_red=x, filt_green=y, filt_blue=x^y yields out_rgba={FF, x^y, y, x} per beat.
- Controls: at (0,0) Left/Top/Red; (39,0) Right/Top/GreenBesideRed; (0,29) Left/Bottom/GreenBesideBlue; (39,29) Right/Bottom/Blue; (5,7) Center/Middle/Blue. With bayer_phase=3, (0,0) gives Blue.
- Backpressure: random out_ready at 30% high. All 1200 pixels delivered once, in order. Held out_* stay unchanged while stalled. Final-pixel stall in DRAIN holds done low.
- Abort at pixel 517 (also abort coincident with start in IDLE): next cycle out_valid=0, busy=0, done never pulses. A following start rescans from (0,0).
- start pulses during RUN and DONE are ignored: beat count stays 1200 and bayer_phase changes mid-frame have no effect.
- reset_n asserted asynchronously mid-frame (pixel 300, out_valid=1): outputs reach their reset values without waiting for a clock edge, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/demosaic_scan_controller.sv
// Raster-scan sequencer for the 3x3 demosaic datapath: drives address, edge and Bayer-phase
// controls, and registers the combinational filter result into a valid/ready RGBA stream.
module demosaic_scan_controller #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned HEIGHT = 30,
  parameter int unsigned X_BITS = 6,
  parameter int unsigned Y_BITS = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        bayer_phase,
  output logic              busy,
  output logic              done,
  output logic [X_BITS-1:0] address_x,
  output logic [Y_BITS-1:0] address_y,
  output logic [1:0]        lateral,
  output logic [1:0]        vertical,
  output logic [1:0]        color,
  input  logic [7:0]        filt_red,
  input  logic [7:0]        filt_green,
  input  logic [7:0]        filt_blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_BITS-1:0] out_x,
  output logic [Y_BITS-1:0] out_y,
  output logic [31:0]       out_rgba
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [X_BITS-1:0] XLast = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] YLast = Y_BITS'(HEIGHT - 1);

  state_e            state_q;
  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic [1:0]        phase_q;
  logic              out_valid_q;
  logic [X_BITS-1:0] out_x_q;
  logic [Y_BITS-1:0] out_y_q;
  logic [31:0]       out_rgba_q;
  logic              busy_q;
  logic              done_q;

  logic issue;
  logic last_pixel;

  // The output register can take a new pixel when empty or being drained this cycle.
  assign issue      = !out_valid_q || out_ready;
  assign last_pixel = (x_q == XLast) && (y_q == YLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_rgba_q  <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            phase_q <= bayer_phase;
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (issue) begin
            out_valid_q <= 1'b1;
            out_x_q     <= x_q;
            out_y_q     <= y_q;
            out_rgba_q  <= {8'hFF, filt_blue, filt_green, filt_red};
            if (last_pixel) begin
              x_q     <= '0;
              y_q     <= '0;
              state_q <= StDrain;
            end else if (x_q == XLast) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic px;
  logic py;

  always_comb begin
    lateral = 2'd1;
    if (x_q == '0) begin
      lateral = 2'd0;
    end else if (x_q == XLast) begin
      lateral = 2'd2;
    end
    vertical = 2'd1;
    if (y_q == '0) begin
      vertical = 2'd0;
    end else if (y_q == YLast) begin
      vertical = 2'd2;
    end
    px    = x_q[0] ^ phase_q[0];
    py    = y_q[0] ^ phase_q[1];
    color = 2'd0;
    unique case ({px, py})
      2'b00: color = 2'd0;
      2'b11: color = 2'd1;
      2'b10: color = 2'd2;
      2'b01: color = 2'd3;
      default: color = 2'd0;
    endcase
  end

  assign address_x = x_q;
  assign address_y = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_rgba  = out_rgba_q;

endmodule

// File: tb/tb_demosaic_scan_controller.sv
// Directed bench for demosaic_scan_controller: full frames, controls, backpressure,
// ignored starts, abort and asynchronous reset.
module tb_demosaic_scan_controller;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [1:0] bayer_phase;
  logic       busy;
  logic       done;
  logic [5:0] address_x;
  logic [4:0] address_y;
  logic [1:0] lateral;
  logic [1:0] vertical;
  logic [1:0] color;
  logic [7:0] filt_red;
  logic [7:0] filt_green;
  logic [7:0] filt_blue;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_x;
  logic [4:0] out_y;
  logic [31:0] out_rgba;

  int checks = 0;
  int errors = 0;

  // Coordinates and hand-derived controls of the probe pixels.
  int         pt_idx [5] = '{0, 39, 1160, 1199, 285};
  logic [1:0] pt_lat [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1};
  logic [1:0] pt_vert[5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
  logic [1:0] pt_col0[5] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd1};
  logic [1:0] pt_col3[5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};

  demosaic_scan_controller #(
    .WIDTH (40),
    .HEIGHT(30),
    .X_BITS(6),
    .Y_BITS(5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .bayer_phase(bayer_phase),
    .busy       (busy),
    .done       (done),
    .address_x  (address_x),
    .address_y  (address_y),
    .lateral    (lateral),
    .vertical   (vertical),
    .color      (color),
    .filt_red   (filt_red),
    .filt_green (filt_green),
    .filt_blue  (filt_blue),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_rgba   (out_rgba)
  );

  // Stub filter: red = x, green = y, blue = x ^ y.
  assign filt_red   = {2'b00, address_x};
  assign filt_green = {3'b000, address_y};
  assign filt_blue  = {2'b00, address_x ^ {1'b0, address_y}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int i);
    logic [5:0] x;
    logic [4:0] y;
    logic [7:0] xb;
    logic [7:0] yb;
    x  = 6'(i % 40);
    y  = 5'(i / 40);
    xb = {2'b00, x};
    yb = {3'b000, y};
    return {21'd0, x, y, 8'hFF, xb ^ yb, yb, xb};
  endfunction

  task automatic run_frame(input logic [1:0] ph, input int pct, input bit poke,
                           input int abort_at, input int reset_at);
    int   idx;
    int   edges;
    int   done_cnt;
    int   done_at;
    int   loaded;
    bit   finished;
    bit   drain_stall;
    bit   saw_done;
    bit   seen[5];
    logic [1:0] col;
    idx = 0; edges = 0; done_cnt = 0; done_at = -1;
    finished = 1'b0; drain_stall = 1'b0; saw_done = 1'b0;
    for (int k = 0; k < 5; k++) seen[k] = 1'b0;
    start = 1'b1;
    bayer_phase = ph;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    while (!finished && edges < 20000) begin
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = edges;
      end
      if (out_valid) check("beat", {21'd0, out_x, out_y, out_rgba}, exp_beat(idx));
      loaded = idx + int'(out_valid);
      for (int k = 0; k < 5; k++) begin
        if (busy && !seen[k] && loaded == pt_idx[k] && (ph == 2'd0 || ph == 2'd3)) begin
          seen[k] = 1'b1;
          col = (ph == 2'd0) ? pt_col0[k] : pt_col3[k];
          check("addr", {53'd0, address_x, address_y}, exp_beat(pt_idx[k]) >> 32);
          check("ctl", {58'd0, lateral, vertical, color}, {58'd0, pt_lat[k], pt_vert[k], col});
        end
      end
      if (abort_at >= 0 && busy && loaded == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_addr", {53'd0, address_x, address_y}, 64'd0);
        repeat (4) begin
          saw_done |= done;
          @(negedge clk);
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        return;
      end
      if (reset_at >= 0 && out_valid && idx == reset_at) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_out", {21'd0, out_x, out_y, out_rgba}, 64'd0);
        check("rst_addr", {53'd0, address_x, address_y}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_idle", {62'd0, busy, out_valid}, 64'd0);
        return;
      end
      if (pct >= 100) begin
        out_ready = 1'b1;
      end else if (idx == 1199 && out_valid && !drain_stall) begin
        out_ready   = 1'b0;
        drain_stall = 1'b1;
        check("drain_stall", {62'd0, busy, done}, 64'd2);
      end else begin
        out_ready = ($urandom_range(0, 99) < pct);
      end
      if (out_valid && out_ready) idx++;
      if (poke && edges >= 100 && edges < 103) begin
        start = 1'b1;
        bayer_phase = ~ph;
      end else begin
        start = poke && done;
      end
      if (done) finished = 1'b1;
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("beats", 64'(idx), 64'd1200);
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_after", {62'd0, busy, done}, 64'd0);
    if (pct >= 100) check("done_edge", 64'(done_at), 64'd1201);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bayer_phase = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_out", {21'd0, out_x, out_y, out_rgba}, 64'd0);
    check("reset_addr", {53'd0, address_x, address_y}, 64'd0);
    check("reset_ctl", {58'd0, lateral, vertical, color}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_no_start", 64'(busy), 64'd0);

    run_frame(2'd0, 100, 1'b0, -1, -1);
    run_frame(2'd3, 100, 1'b0, -1, -1);
    run_frame(2'd0, 30, 1'b0, -1, -1);
    run_frame(2'd0, 100, 1'b1, -1, -1);
    run_frame(2'd0, 100, 1'b0, 517, -1);

    // abort coincident with start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("coinc_busy", {62'd0, busy, out_valid}, 64'd0);
    @(negedge clk);
    check("coinc_done", {62'd0, busy, done}, 64'd0);

    run_frame(2'd0, 100, 1'b0, -1, -1);
    run_frame(2'd0, 100, 1'b0, -1, 300);
    run_frame(2'd0, 100, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
